// File: rtl/ps2_kbd_ascii_if.sv
// PS/2 keyboard front-end bus: raw PS/2 pins in, decoded key information out.
// No latency of its own; pure signal bundle.
// No backpressure: outputs are level/pulse signals sampled by the consumer.
interface ps2_kbd_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic [1:0] state;
  logic [7:0] key_count;
  logic       caps_led;
  logic       parity_err;

  // Keyboard/stimulus side: drives the PS/2 pins, observes decoded outputs.
  modport master (
    output ps2_clk, ps2_data,
    input  ascii, state, key_count, caps_led, parity_err
  );

  // Decoder side: samples the PS/2 pins, drives decoded outputs.
  modport slave (
    input  ps2_clk, ps2_data,
    output ascii, state, key_count, caps_led, parity_err
  );
endinterface

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver + scan-code decoder producing ASCII of the held key.
// Latency: outputs update 4 clk after a raw ps2_clk fall (2 sync, history/receive, decode).
// No backpressure: one code per frame, processed the cycle after it is received.
module ps2_kbd_ascii #(
  parameter int TIMEOUT = 50000
) (
  input logic           clk,
  input logic           clrn,
  ps2_kbd_ascii_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_CAPS  = 8'h58;
  localparam logic [7:0] CODE_LSHFT = 8'h12;
  localparam logic [7:0] CODE_RSHFT = 8'h59;

  typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} dec_t;

  // ---------------- synchroniser ----------------
  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2;
  logic fall;

  // Two-flop synchronisers on both pins plus one history flop for edge detect.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_hist <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
    end else begin
      clk_s1   <= bus.ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= bus.ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_hist & ~clk_s2;

  // ---------------- frame receiver ----------------
  logic [3:0]    bitcnt;
  logic [9:0]    bits;
  logic [CW-1:0] idle;
  logic          code_vld;
  logic          frame_err;
  logic [7:0]    code;

  // Collect 11 bits; on the last one check start/stop/odd parity. A stalled
  // partial frame is dropped silently after TIMEOUT idle cycles; an edge in
  // the same cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      bitcnt    <= 4'd0;
      bits      <= '0;
      idle      <= '0;
      code_vld  <= 1'b0;
      frame_err <= 1'b0;
      code      <= 8'h00;
    end else begin
      code_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt <= 4'd0;
          if (!bits[0] && dat_s2 && (^bits[9:1])) begin
            code_vld <= 1'b1;
            code     <= bits[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bits[bitcnt] <= dat_s2;
          bitcnt       <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        if (idle == TO_LAST) begin
          bitcnt <= 4'd0;
          idle   <= '0;
        end else begin
          idle <= idle + 1'b1;
        end
      end
    end
  end

  // ---------------- scan-code map ----------------
  function automatic logic [7:0] key_map(input logic [7:0] c, input logic upper);
    logic [7:0] r;
    logic       letter;
    logic [4:0] idx;
    r      = 8'h00;
    letter = 1'b1;
    idx    = 5'd0;
    case (c)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      r = (upper ? 8'h41 : 8'h61) + {3'b000, idx};
    end else begin
      case (c)
        8'h45: r = 8'h30;  8'h16: r = 8'h31;  8'h1E: r = 8'h32;
        8'h26: r = 8'h33;  8'h25: r = 8'h34;  8'h2E: r = 8'h35;
        8'h36: r = 8'h36;  8'h3D: r = 8'h37;  8'h3E: r = 8'h38;
        8'h46: r = 8'h39;
        8'h29: r = 8'h20;  8'h5A: r = 8'h0D;  8'h66: r = 8'h08;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // ---------------- decoder ----------------
  dec_t       dec, dec_nxt;
  logic [7:0] ascii_r, ascii_nxt;
  logic [1:0] st_r, st_nxt;
  logic [7:0] cnt_r, cnt_nxt;
  logic       caps_r, caps_nxt;
  logic       shift_r, shift_nxt;
  logic [7:0] last_r, last_nxt;
  logic       perr_r, perr_nxt;
  logic       is_shift;

  // Decoder state and output registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      dec     <= NORMAL;
      ascii_r <= 8'h00;
      st_r    <= 2'b00;
      cnt_r   <= 8'h00;
      caps_r  <= 1'b0;
      shift_r <= 1'b0;
      last_r  <= 8'h00;
      perr_r  <= 1'b0;
    end else begin
      dec     <= dec_nxt;
      ascii_r <= ascii_nxt;
      st_r    <= st_nxt;
      cnt_r   <= cnt_nxt;
      caps_r  <= caps_nxt;
      shift_r <= shift_nxt;
      last_r  <= last_nxt;
      perr_r  <= perr_nxt;
    end
  end

  assign is_shift = (code == CODE_LSHFT) || (code == CODE_RSHFT);

  // Prefix tracking plus make/break handling; release state 10 decays to 00.
  always_comb begin
    dec_nxt   = dec;
    ascii_nxt = ascii_r;
    st_nxt    = (st_r == 2'b10) ? 2'b00 : st_r;
    cnt_nxt   = cnt_r;
    caps_nxt  = caps_r;
    shift_nxt = shift_r;
    last_nxt  = last_r;
    perr_nxt  = frame_err;
    if (code_vld) begin
      case (dec)
        NORMAL: begin
          if (code == CODE_BRK) begin
            dec_nxt = BREAK;
          end else if (code == CODE_EXT) begin
            dec_nxt = EXT;
          end else if (is_shift) begin
            shift_nxt = 1'b1;
          end else if (code == CODE_CAPS) begin
            if (last_r != CODE_CAPS) caps_nxt = ~caps_r;
            last_nxt = CODE_CAPS;
          end else if (!(code == last_r && st_r == 2'b01)) begin
            last_nxt  = code;
            ascii_nxt = key_map(code, shift_r ^ caps_r);
            st_nxt    = 2'b01;
            cnt_nxt   = cnt_r + 8'd1;
          end
        end
        EXT:       dec_nxt = (code == CODE_BRK) ? EXT_BREAK : NORMAL;
        EXT_BREAK: dec_nxt = NORMAL;
        BREAK: begin
          dec_nxt = NORMAL;
          if (is_shift) begin
            shift_nxt = 1'b0;
          end else if (code == last_r && st_r == 2'b01) begin
            st_nxt   = 2'b10;
            last_nxt = 8'h00;
          end else if (code == CODE_CAPS) begin
            last_nxt = 8'h00;
          end
        end
      endcase
    end
  end

  assign bus.ascii      = ascii_r;
  assign bus.state      = st_r;
  assign bus.key_count  = cnt_r;
  assign bus.caps_led   = caps_r;
  assign bus.parity_err = perr_r;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Self-checking bench for ps2_kbd_ascii: directed scenarios then random frames
// compared cycle-accurately against a byte-level behavioural model.
module tb_ps2_kbd_ascii;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 8;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_kbd_ascii_if bus();

  ps2_kbd_ascii #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state
  logic [7:0] m_ascii, m_count, m_last;
  logic [1:0] m_state;
  logic       m_caps, m_shift, m_ext, m_brk, m_pulse, m_perr;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_map(input logic [7:0] c);
    for (int i = 0; i < 26; i++)
      if (letters[i] == c) return ((m_shift ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ascii = 0; m_count = 0; m_last = 0; m_state = 0;
    m_caps = 0; m_shift = 0; m_ext = 0; m_brk = 0; m_pulse = 0; m_perr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic sh;
    sh = (b == 8'h12) || (b == 8'h59);
    if (m_ext) begin
      if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (sh) m_shift = 0;
      else if (b == m_last && m_state == 2'b01) begin m_pulse = 1; m_state = 0; m_last = 0; end
      else if (b == 8'h58) m_last = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (sh) m_shift = 1;
    else if (b == 8'h58) begin
      if (m_last != 8'h58) m_caps = ~m_caps;
      m_last = 8'h58;
    end else if (!(b == m_last && m_state == 2'b01)) begin
      m_last = b; m_ascii = ref_map(b); m_state = 2'b01; m_count = m_count + 8'd1;
    end
  endtask

  task automatic check_all(input string p, input logic [1:0] es, input logic ep);
    chk({p, "_ascii"}, bus.ascii, m_ascii);
    chk({p, "_state"}, bus.state, es);
    chk({p, "_count"}, bus.key_count, m_count);
    chk({p, "_caps"},  bus.caps_led, m_caps);
    chk({p, "_perr"},  bus.parity_err, ep);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) bus.ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("pre", m_state, 1'b0);
        m_pulse = 0;
        m_perr  = bad_par | bad_stop;
        if (!m_perr) model_byte(d);
        @(posedge clk);
        @(negedge clk);
        check_all("post", m_pulse ? 2'b10 : m_state, m_perr);
        @(posedge clk);
        @(negedge clk);
        chk("settle_state", bus.state, m_state);
        chk("settle_perr", bus.parity_err, 0);
        bus.ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.ps2_data = (i == 0) ? 1'b0 : 1'b1;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic do_reset(input string p);
    @(negedge clk) clrn = 1'b0;
    @(posedge clk);
    @(negedge clk) clrn = 1'b1;
    model_reset();
    check_all(p, 2'b00, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    clrn = 1'b1;
    check_all("rst", 2'b00, 1'b0);

    // press/release 'a'
    send_frame(8'h1C, 0, 0);
    chk("t1_ascii", bus.ascii, 8'h61);
    chk("t1_count", bus.key_count, 8'd1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("t1_rel_ascii", bus.ascii, 8'h61);

    // typematic repeat
    repeat (3) send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("t2_count", bus.key_count, 8'd2);

    // shift and caps
    send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("t3_shift_a", bus.ascii, 8'h41);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("t3_plain_a", bus.ascii, 8'h61);
    send_frame(8'h58, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h58, 0, 0);
    send_frame(8'h15, 0, 0);
    chk("t3_caps", bus.caps_led, 1'b1);
    chk("t3_caps_q", bus.ascii, 8'h51);

    // bad parity, bad stop
    do_reset("rst2");
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 0, 1);
    chk("t4_count", bus.key_count, 8'd0);
    send_frame(8'h32, 0, 0);
    chk("t4_b", bus.ascii, 8'h62);

    // partial frame timeout
    send_bits(5);
    repeat (TIMEOUT + 20) @(negedge clk);
    send_frame(8'h29, 0, 0);
    chk("t5_space", bus.ascii, 8'h20);
    chk("t5_state", bus.state, 2'b01);

    // extended keys ignored
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    chk("t6_ext_ascii", bus.ascii, 8'h20);

    // reset mid-frame
    send_bits(4);
    do_reset("rst3");
    send_frame(8'h45, 0, 0);
    chk("t6_zero", bus.ascii, 8'h30);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 15))
        0:  b = 8'h1C;  1: b = 8'h32;  2: b = 8'h21;  3: b = 8'h15;
        4:  b = 8'h45;  5: b = 8'h16;  6: b = 8'h66;  7: b = 8'h12;
        8:  b = 8'h59;  9: b = 8'h58;  10: b = 8'hE0;
        11, 12: b = 8'hF0;
        13, 14: b = m_last;
        default: b = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 11))
        0:       send_frame(b, 1, 0);
        1:       send_frame(b, 0, 1);
        default: send_frame(b, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ascii.md
Name: ps2_kbd_ascii

Overview:
- PS/2 keyboard front end that feeds the typing-game core its `kbd_ascii` and `state` inputs.
- Receives 11-bit PS/2 frames and validates framing and parity.
- Decodes make, break and E0-prefixed scan-code sequences, applies Shift/CapsLock, and presents the ASCII of the currently held key.
- The game core samples `ascii` only while `state == 2'b01`.

Parameters:
TIMEOUT, 50000, clk cycles without a ps2_clk falling edge after which a partial frame is discarded (1 ms at 50 MHz).

Ports:
clk  input  1  system clock (50 MHz); all logic on posedge.
clrn  input  1  reset, synchronous, active-low.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
ps2_data  input  1  raw PS/2 data pin, asynchronous.
ascii  output  8  ASCII of last mapped make key; 0x00 for unmapped.
state  output  2  00 idle, 01 key held, 10 release pulse; 11 never driven.
key_count  output  8  count of accepted new make events, wraps 255->0.
caps_led  output  1  CapsLock toggle state.
parity_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset and clocking:
  - Only clk and clrn are used: one clock, synchronous active-low reset.
  - clrn==0 at a posedge: all outputs 0; receiver, prefix flags, shift_held and last_code cleared.
  - Reset mid-frame abandons the frame.
- Synchronisation and sampling:
  - ps2_clk and ps2_data each pass through 2 flops, then one history flop for ps2_clk.
  - A falling edge is history==1 and sync==0.
  - ps2_data (synchronised) is sampled on each falling edge into bit position bitcnt 0..10.
- Frame check:
  - Frame = start(0), d0..d7 LSB first, odd parity, stop(1).
  - On the 11th edge, the frame is accepted only if start==0, stop==1 and XOR(d0..d7, parity)==1.
  - Otherwise parity_err pulses for 1 cycle and the code is discarded.
  - bitcnt returns to 0 in both cases.
- Timeout:
  - An idle counter runs while bitcnt!=0 and is cleared on every edge.
  - When it reaches TIMEOUT, bitcnt goes to 0 with no error pulse.
- Latency: an accepted code updates outputs exactly 4 clk after a raw ps2_clk fall that meets setup to clk (2 sync flops + history + decode register).
- Decoder FSM:
  - States: NORMAL, BREAK (after F0), EXT (after E0), EXT_BREAK (after E0 F0).
  - NORMAL: F0->BREAK; E0->EXT; otherwise process make, stay NORMAL.
  - EXT: F0->EXT_BREAK; any other code ignored, ->NORMAL.
  - EXT_BREAK: any code ignored, ->NORMAL.
  - BREAK: process break, ->NORMAL.
- Make processing:
  - Shift (0x12, 0x59): set shift_held; ascii and state unchanged.
  - CapsLock 0x58: toggle caps_led only if last_code!=0x58 (auto-repeat ignored); set last_code.
  - Any other code equal to last_code while state==01: typematic repeat, ignored.
  - Otherwise:
    - last_code<=code; ascii<=map(code); state<=01; key_count+1.
    - Unmapped codes give ascii 0x00.
- Map:
  - Letters: a..z = 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
    - Output 0x61+i, or 0x41+i when shift_held XOR caps_led.
  - Digits: 0..9 = 45 16 1E 26 25 2E 36 3D 3E 46 -> 0x30..0x39; unaffected by Shift and Caps.
  - Control keys: 29->0x20, 5A->0x0D, 66->0x08.
- Break processing:
  - Shift code: clear shift_held.
  - Code == last_code with state==01: state<=10 for exactly 1 cycle, then 00; last_code<=0; ascii retained.
  - Break of 0x58: last_code<=0.
  - Any other break: ignored.
- Simultaneous events: a timeout coinciding with the 11th edge -> the edge wins and the frame is checked. Only one code is processed per cycle.

Test Plan:
- Frame 0x1C (valid parity) -> 4 clk after the 11th fall: ascii=0x61, state=01, key_count=1. Then F0,1C -> state=10 for 1 cycle, then 00; ascii stays 0x61.
- 0x1C sent three times (repeat), then F0 1C -> key_count=1, single 10 pulse.
- 12, 1C, F0 1C, F0 12, 1C -> first ascii=0x41, after Shift release ascii=0x61. Then 58, F0 58, 15 -> caps_led=1, ascii=0x51.
- Frame 0x1C with bad parity -> parity_err one-cycle pulse; ascii, state and key_count unchanged. Next good 0x32 -> ascii=0x62.
- 5 bits of a frame, then idle > TIMEOUT clk, then full 0x29 -> ascii=0x20, state=01, no parity_err.
- E0 75, E0 F0 75 -> outputs unchanged. clrn=0 asserted mid-frame for 1 clk -> all outputs 0; next frame 0x45 -> ascii=0x30.
